pwm: RTL and testbench
======================

Name: pwm

Overview:
- Counter-based pulse-width modulator with a programmable period and a programmable high time.
- Period is `cycle` clocks; high time is `duty` clocks. Both are runtime inputs, captured into shadow registers at period boundaries so the output never glitches mid-period.
- Used as a general-purpose PWM leaf (LED dimming, motor drive) clocked by the system clock.

Parameters:
- WIDTH, 32, width of the period counter, `cycle` and `duty`. Must satisfy 2^WIDTH > maximum `cycle` used.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous active-low reset; sampled on the rising edge of clk.
- en  input  1  enable; 0 = idle, output low.
- cycle  input  WIDTH  PWM period in clk cycles.
- duty  input  WIDTH  high time in clk cycles; intended duty < cycle, any value is legal.
- pwm_out  output  1  registered PWM output.

Behaviour:
- State: period counter cnt[WIDTH-1:0], shadow period cyc_s[WIDTH-1:0], shadow duty duty_s[WIDTH-1:0], registered pwm_out.
- Reset (rst_n=0 at a clk edge): cnt=0, cyc_s=0, duty_s=0, pwm_out=0.
  - Reset has priority over en and applies mid-period without waiting for a boundary.
- Idle (rst_n=1, en=0 at an edge): cnt=0, pwm_out=0, cyc_s<=cycle, duty_s<=duty. Shadows track the inputs while idle.
- Run (rst_n=1, en=1 at an edge):
  - pwm_out <= (cyc_s != 0) && (cnt < duty_s). The output reflects the pre-edge cnt and shadows, giving a one-clock pipeline.
  - Boundary when cyc_s == 0 or cnt >= cyc_s-1: cnt<=0, cyc_s<=cycle, duty_s<=duty.
  - Otherwise: cnt<=cnt+1.
- Result: period = cyc_s clocks; pwm_out high for min(duty_s, cyc_s) consecutive clocks, then low for the remainder.
- Latency: pwm_out first reflects the new setting on the first edge where en is sampled high. Example: cycle=10, duty=5 gives high for the edges where cnt=0..4, then low for cnt=5..9, repeating.
- Changes to cycle or duty while running take effect only at the next boundary; the current period completes unchanged.
- Comparisons are unsigned WIDTH-bit; no arithmetic overflow is possible because cyc_s-1 is only evaluated when cyc_s != 0.
- Boundary cases:
  - cycle=0: pwm_out=0 constantly; cnt held at 0; shadows reload every clock.
  - duty=0: pwm_out=0 constantly.
  - duty >= cycle (cycle != 0): pwm_out=1 constantly.
  - cycle=1: cnt stays 0; pwm_out = (duty != 0).
  - en dropping mid-period: pwm_out=0 on the next edge; cnt=0. On re-enable a fresh period starts at cnt=0 with the current inputs.
  - After reset release with en=1: the first edge sees cyc_s=0, so pwm_out stays low and the shadows load. The normal pattern starts on the following edge.
- Inputs are sampled only on clk; no asynchronous paths.

Optional Feature:
- PWM_PERIOD_STROBE_EN
  - Defined: adds output port period_strobe (1 bit, registered). It pulses 1 for exactly one clock on the edge where a run-mode boundary reload occurs with cyc_s != 0, i.e. once per completed period. It is 0 in reset, in idle, and while cyc_s == 0.
  - Not defined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset then release: en=1, cycle=duty=0, rst_n low for several clocks then high -> pwm_out=0 throughout; no X after the first reset edge.
- cycle=10, duty=5, en=1 steady -> pwm_out repeats 5 clocks high / 5 low with period exactly 10 clocks, checked over at least 1000 periods.
- cycle=10, duty=8, then duty=2 with en pulsed low between settings -> 8 high/2 low, then 2 high/8 low. pwm_out=0 while en=0 and on the first edge after en drops; a new period starts at cnt=0 on re-enable.
- Change duty from 5 to 8 at cnt=3 without toggling en -> current period finishes as 5 high/5 low; the next period is 8 high/2 low; no runt pulse.
- Edge values: cycle=10, duty=12 -> constant 1. duty=0 -> constant 0. cycle=0, duty=5 -> constant 0. cycle=1, duty=1 -> constant 1.
- Assert rst_n=0 mid-high-phase with en=1 -> pwm_out=0 on that edge. After release: one low clock, then the pattern restarts from cnt=0.

Source files
------------

// File: rtl/pwm.sv
// -----------------------------------------------------------------------------
// pwm -- counter-based pulse-width modulator
//
// Purpose:
//   Produces a registered PWM waveform whose period is `cycle` clocks and whose
//   high time is `duty` clocks. Both settings are captured into shadow
//   registers only at period boundaries (or continuously while idle), so a
//   change in the middle of a period never produces a runt or stretched pulse.
//
// Parameters:
//   WIDTH          width of the period counter, `cycle` and `duty`
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          synchronous active-low reset
//   en             enable; 0 = idle (output low, shadows track inputs)
//   cycle          PWM period in clk cycles (0 = output held low)
//   duty           high time in clk cycles (>= cycle gives constant high)
//   pwm_out        registered PWM output
//   period_strobe  (only with PWM_PERIOD_STROBE_EN) one-clock pulse on the
//                  edge that completes a period with a non-zero shadow period
//
// Optional feature macro: PWM_PERIOD_STROBE_EN
// -----------------------------------------------------------------------------
module pwm #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] cycle,
  input  logic [WIDTH-1:0] duty,
`ifdef PWM_PERIOD_STROBE_EN
  output logic             period_strobe,
`endif
  output logic             pwm_out
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] cyc_s_q, cyc_s_d;
  logic [WIDTH-1:0] duty_s_q, duty_s_d;
  logic             pwm_q, pwm_d;
  logic             boundary;

  // The zero test short-circuits the wrapped value of cyc_s_q-1, so a zero
  // period is treated as a boundary on every clock rather than a huge period.
  assign boundary = (cyc_s_q == '0) || (cnt_q >= (cyc_s_q - WIDTH'(1)));

  always_comb begin
    cnt_d    = cnt_q;
    cyc_s_d  = cyc_s_q;
    duty_s_d = duty_s_q;
    pwm_d    = 1'b0;
    if (!en) begin
      // Idle: hold the counter at the start of a period and keep the shadows
      // current so re-enabling starts a fresh period with the latest inputs.
      cnt_d    = '0;
      cyc_s_d  = cycle;
      duty_s_d = duty;
    end else begin
      // Output is decided from the pre-edge counter and shadows.
      pwm_d = (cyc_s_q != '0) && (cnt_q < duty_s_q);
      if (boundary) begin
        cnt_d    = '0;
        cyc_s_d  = cycle;
        duty_s_d = duty;
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      cyc_s_q  <= '0;
      duty_s_q <= '0;
      pwm_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      cyc_s_q  <= cyc_s_d;
      duty_s_q <= duty_s_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

`ifdef PWM_PERIOD_STROBE_EN
  logic strobe_q, strobe_d;

  // A reload with a non-zero shadow period marks the end of a real period;
  // the every-clock reloads of a zero period are not periods.
  always_comb begin
    strobe_d = 1'b0;
    if (en && boundary && (cyc_s_q != '0)) begin
      strobe_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= strobe_d;
    end
  end

  assign period_strobe = strobe_q;
`endif

endmodule

// File: tb/tb_pwm.sv
// -----------------------------------------------------------------------------
// tb_pwm -- self-checking bench for pwm
//
// Expected pwm_out values are written as waveform fragments (runs of highs and
// lows) into a scoreboard queue when each stimulus step is set up; the queue is
// then drained one entry per clock edge and compared against the DUT output
// sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pwm;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic [W-1:0] cycle;
  logic [W-1:0] duty;
  logic         pwm_out;
`ifdef PWM_PERIOD_STROBE_EN
  logic         period_strobe;
`endif

  int checks;
  int errors;
  int step_no;
  bit exp_q[$];

  pwm #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .cycle         (cycle),
    .duty          (duty),
`ifdef PWM_PERIOD_STROBE_EN
    .period_strobe (period_strobe),
`endif
    .pwm_out       (pwm_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Push n copies of a constant level.
  task automatic push_n(input bit v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  // Push reps periods of `hi` high clocks followed by `lo` low clocks.
  task automatic push_period(input int hi, input int lo, input int reps);
    for (int r = 0; r < reps; r++) begin
      push_n(1'b1, hi);
      push_n(1'b0, lo);
    end
  endtask

  // One clock edge: pop the expected level and compare.
  task automatic step(input string tag);
    bit e;
    @(posedge clk);
    #1;
    step_no++;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s step %0d: scoreboard empty, observed %b", tag, step_no, pwm_out);
    end else begin
      e = exp_q.pop_front();
      assert (pwm_out === e) else begin
        errors++;
        $error("FAIL %s step %0d: pwm_out observed %b expected %b", tag, step_no, pwm_out, e);
      end
    end
  endtask

  // Drain every queued expectation; bounded by the queue length.
  task automatic drain(input string tag);
    while (exp_q.size() > 0) step(tag);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    step_no = 0;
    rst_n   = 1'b0;
    en      = 1'b1;
    cycle   = '0;
    duty    = '0;

    // Reset held with en=1: output low from the first edge, no X.
    push_n(1'b0, 5);
    drain("reset_hold");

    // Release with cycle=0: first edge loads shadows, output stays low.
    rst_n = 1'b1;
    push_n(1'b0, 4);
    drain("reset_release_cycle0");

    // 10/5 from idle, 1000 periods of 5 high / 5 low.
    en = 1'b0; cycle = 32'd10; duty = 32'd5;
    push_n(1'b0, 1);
    drain("idle_load_10_5");
    en = 1'b1;
    push_period(5, 5, 1000);
    drain("steady_10_5");

    // 10/8 via idle, two periods.
    en = 1'b0; duty = 32'd8;
    push_n(1'b0, 1);
    drain("idle_load_10_8");
    en = 1'b1;
    push_period(8, 2, 2);
    push_n(1'b1, 3);
    drain("run_10_8");

    // en drops mid high phase: low on the very next edge and while idle.
    en = 1'b0; duty = 32'd2;
    push_n(1'b0, 2);
    drain("en_drop_midperiod");
    en = 1'b1;
    push_period(2, 8, 2);
    drain("reenable_10_2");

    // duty changed during a period only affects the following period.
    duty = 32'd5;
    push_period(2, 8, 1);
    push_n(1'b1, 3);
    drain("duty_2_to_5");
    duty = 32'd8;                 // cnt is 3 here
    push_n(1'b1, 2);
    push_n(1'b0, 5);
    push_period(8, 2, 2);
    drain("duty_5_to_8_mid");

    // Edge values, each entered through one idle clock.
    en = 1'b0; cycle = 32'd10; duty = 32'd12;
    push_n(1'b0, 1);
    drain("idle_10_12");
    en = 1'b1;
    push_n(1'b1, 25);
    drain("duty_gt_cycle");

    en = 1'b0; cycle = 32'd10; duty = 32'd0;
    push_n(1'b0, 1);
    drain("idle_10_0");
    en = 1'b1;
    push_n(1'b0, 25);
    drain("duty_zero");

    en = 1'b0; cycle = 32'd0; duty = 32'd5;
    push_n(1'b0, 1);
    drain("idle_0_5");
    en = 1'b1;
    push_n(1'b0, 25);
    drain("cycle_zero");

    en = 1'b0; cycle = 32'd1; duty = 32'd1;
    push_n(1'b0, 1);
    drain("idle_1_1");
    en = 1'b1;
    push_n(1'b1, 25);
    drain("cycle_one");

    // Reset in the middle of the high phase.
    en = 1'b0; cycle = 32'd10; duty = 32'd5;
    push_n(1'b0, 1);
    drain("idle_10_5_again");
    en = 1'b1;
    push_n(1'b1, 3);
    drain("pre_reset_high");
    rst_n = 1'b0;
    push_n(1'b0, 2);
    drain("reset_mid_high");
    rst_n = 1'b1;
    push_n(1'b0, 1);
    push_period(5, 5, 2);
    drain("after_reset_restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
